// File: rtl/core_pkg.sv
// Shared core definitions: RV32I load/store width codes, responder FSM states,
// and the request legality check.
package core_pkg;

    localparam logic [2:0] Funct3B  = 3'b000;
    localparam logic [2:0] Funct3H  = 3'b001;
    localparam logic [2:0] Funct3W  = 3'b010;
    localparam logic [2:0] Funct3Bu = 3'b100;
    localparam logic [2:0] Funct3Hu = 3'b101;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StWait = 2'b01,
        StResp = 2'b10
    } resp_state_e;

    // Width/alignment legality only; the address range check lives in the responder.
    function automatic logic req_error(input logic [2:0] funct3, input logic we,
                                       input logic [1:0] lsb);
        case (funct3)
            Funct3B:  return 1'b0;
            Funct3H:  return lsb[0];
            Funct3W:  return lsb != 2'b00;
            Funct3Bu: return we;
            Funct3Hu: return we | lsb[0];
            default:  return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/load_align_extend.sv
// Selects the addressed byte/half from a memory word and sign- or zero-extends it.
module load_align_extend
    import core_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  addr,
    input  logic [2:0]  funct3,
    output logic [31:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word[7:0];
        unique case (addr)
            2'd0: byte_sel = word[7:0];
            2'd1: byte_sel = word[15:8];
            2'd2: byte_sel = word[23:16];
            2'd3: byte_sel = word[31:24];
        endcase
        half_sel = addr[1] ? word[31:16] : word[15:0];
    end

    always_comb begin
        result = '0;
        case (funct3)
            Funct3B:  result = {{24{byte_sel[7]}}, byte_sel};
            Funct3H:  result = {{16{half_sel[15]}}, half_sel};
            Funct3W:  result = word;
            Funct3Bu: result = {24'h0, byte_sel};
            Funct3Hu: result = {16'h0, half_sel};
            default:  result = '0;
        endcase
    end

endmodule

// File: rtl/data_memory_responder.sv
// Single-outstanding load/store responder over a word-organised data memory,
// with a configurable fixed response delay and a held response under back-pressure.
module data_memory_responder
    import core_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned WAIT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int unsigned IdxW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    logic [31:0]     mem [DEPTH_WORDS];
    logic [IdxW-1:0] idx;
    logic            in_range;
    logic            err;
    logic            accept;
    logic [31:0]     word;
    logic [31:0]     load_result;
    logic [31:0]     rsp_val;
    logic [3:0]      byte_en;
    logic [31:0]     wdata_lanes;

    resp_state_e state_q;
    logic [3:0]  cnt_q;
    logic [31:0] pend_rdata_q;
    logic        pend_err_q;

    // Full-width compare so high address bits flag an error instead of aliasing.
    assign in_range  = {2'b00, req_addr[31:2]} < DEPTH_WORDS;
    assign idx       = req_addr[IdxW+1:2];
    assign err       = !in_range || req_error(req_funct3, req_we, req_addr[1:0]);
    assign req_ready = reset && (state_q == StIdle);
    assign accept    = req_valid && req_ready;
    assign word      = mem[idx];
    assign rsp_val   = (req_we || err) ? 32'h0 : load_result;

    load_align_extend u_align (
        .word   (word),
        .addr   (req_addr[1:0]),
        .funct3 (req_funct3),
        .result (load_result)
    );

    always_comb begin
        byte_en     = 4'b0000;
        wdata_lanes = req_wdata;
        case (req_funct3)
            Funct3B: begin
                byte_en     = 4'b0001 << req_addr[1:0];
                wdata_lanes = {4{req_wdata[7:0]}};
            end
            Funct3H: begin
                byte_en     = req_addr[1] ? 4'b1100 : 4'b0011;
                wdata_lanes = {2{req_wdata[15:0]}};
            end
            Funct3W: byte_en = 4'b1111;
            default: byte_en = 4'b0000;
        endcase
    end

    // Storage is deliberately outside the reset domain.
    always_ff @(posedge clk) begin
        if (accept && req_we && !err) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en[b]) mem[idx][8*b +: 8] <= wdata_lanes[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            pend_rdata_q <= '0;
            pend_err_q   <= 1'b0;
            rsp_valid    <= 1'b0;
            rsp_rdata    <= '0;
            rsp_err      <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (accept) begin
                        pend_rdata_q <= rsp_val;
                        pend_err_q   <= err;
                        if (WAIT_CYCLES == 0) begin
                            state_q   <= StResp;
                            rsp_valid <= 1'b1;
                            rsp_rdata <= rsp_val;
                            rsp_err   <= err;
                        end else begin
                            state_q <= StWait;
                            cnt_q   <= 4'(WAIT_CYCLES - 1);
                        end
                    end
                end
                StWait: begin
                    if (cnt_q == 4'd0) begin
                        state_q   <= StResp;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= pend_rdata_q;
                        rsp_err   <= pend_err_q;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                StResp: begin
                    if (rsp_ready) begin
                        state_q   <= StIdle;
                        rsp_valid <= 1'b0;
                        rsp_rdata <= '0;
                        rsp_err   <= 1'b0;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_data_memory_responder.sv
// Scoreboard bench: one responder with no wait states and one with three,
// sharing clock, reset and request buses, selected by sel.
module tb_data_memory_responder;

    localparam logic [2:0] FB = 3'b000, FH = 3'b001, FW = 3'b010, FBU = 3'b100, FHU = 3'b101;

    typedef struct packed {logic [31:0] rdata; logic err;} exp_t;
    typedef struct packed {
        logic we; logic [2:0] f3; logic [31:0] addr; logic [31:0] wdata;
        logic [31:0] rdata; logic err;
    } txn_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset = 1'b0, req_valid = 1'b0, req_we = 1'b0, rsp_ready = 1'b1, sel = 1'b0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic [2:0]  req_funct3 = '0;
    logic rr0, rv0, re0, rr3, rv3, re3;
    logic [31:0] rd0, rd3;
    logic req_ready, rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;

    assign req_ready = sel ? rr3 : rr0;
    assign rsp_valid = sel ? rv3 : rv0;
    assign rsp_err   = sel ? re3 : re0;
    assign rsp_rdata = sel ? rd3 : rd0;

    data_memory_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .reset(reset), .req_valid(req_valid && !sel), .req_ready(rr0),
        .req_we(req_we), .req_addr(req_addr), .req_funct3(req_funct3), .req_wdata(req_wdata),
        .rsp_valid(rv0), .rsp_ready(rsp_ready), .rsp_rdata(rd0), .rsp_err(re0)
    );

    data_memory_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(3)) dut3 (
        .clk(clk), .reset(reset), .req_valid(req_valid && sel), .req_ready(rr3),
        .req_we(req_we), .req_addr(req_addr), .req_funct3(req_funct3), .req_wdata(req_wdata),
        .rsp_valid(rv3), .rsp_ready(rsp_ready), .rsp_rdata(rd3), .rsp_err(re3)
    );

    int   checks = 0;
    int   fails  = 0;
    exp_t sb[$];

    // Presents a request and returns at 1ns past the accepting edge.
    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, output logic ok);
        ok = 1'b0;
        @(negedge clk);
        req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (req_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (ok) begin
            @(posedge clk);
            #1;
        end
        req_valid = 1'b0;
        checks++;
        if (!ok) begin
            fails++;
            $display("FAIL accept addr=%h: req_ready stayed 0 for 20 cycles, required 1", addr);
        end
    endtask

    // Waits for rsp_valid (latency counted in cycles after the accepting edge) and pops.
    task automatic collect(output logic [31:0] act_rdata, output logic act_err,
                           output exp_t e, output int lat);
        lat = 1;
        while (!rsp_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        act_rdata = rsp_rdata;
        act_err   = rsp_err;
        e = (sb.size() > 0) ? sb.pop_front() : '0;
        if (rsp_valid && rsp_ready) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({rr0, rr3, rv0, rv3, re0, re3, rd0, rd3} !== '0) begin
            fails++;
            $display("FAIL reset_state got ready=%b%b valid=%b%b err=%b%b rdata=%h/%h, required all 0",
                     rr0, rr3, rv0, rv3, re0, re3, rd0, rd3);
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (rr0 !== 1'b1 || rr3 !== 1'b1 || rv0 !== 1'b0 || rv3 !== 1'b0) begin
            fails++;
            $display("FAIL reset_release got ready=%b%b valid=%b%b, required ready=11 valid=00",
                     rr0, rr3, rv0, rv3);
        end
    endtask

    task automatic test_word_and_extend();
        txn_t tbl [8] = '{
            {1'b1, FW,  32'h10, 32'hDEADBEEF, 32'h00000000, 1'b0},
            {1'b0, FW,  32'h10, 32'h0,        32'hDEADBEEF, 1'b0},
            {1'b0, FB,  32'h13, 32'h0,        32'hFFFFFFDE, 1'b0},
            {1'b0, FBU, 32'h13, 32'h0,        32'h000000DE, 1'b0},
            {1'b0, FH,  32'h12, 32'h0,        32'hFFFFDEAD, 1'b0},
            {1'b0, FHU, 32'h12, 32'h0,        32'h0000DEAD, 1'b0},
            {1'b0, FB,  32'h10, 32'h0,        32'hFFFFFFEF, 1'b0},
            {1'b0, FH,  32'h10, 32'h0,        32'hFFFFBEEF, 1'b0}
        };
        logic ok, ae;
        logic [31:0] ar;
        exp_t e;
        int lat;
        sel = 1'b0;
        foreach (tbl[i]) begin
            sb.push_back({tbl[i].rdata, tbl[i].err});
            issue(tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wdata, ok);
            if (!ok) begin
                void'(sb.pop_back());
                continue;
            end
            collect(ar, ae, e, lat);
            checks++;
            if (ar !== e.rdata || ae !== e.err || lat != 1) begin
                fails++;
                $display("FAIL word_extend[%0d] got rdata=%h err=%b lat=%0d, required rdata=%h err=%b lat=1",
                         i, ar, ae, lat, e.rdata, e.err);
            end
        end
    endtask

    task automatic test_byte_store_and_errors();
        txn_t tbl [20] = '{
            {1'b1, FB,     32'h11,       32'h00000055, 32'h0,        1'b0},
            {1'b0, FW,     32'h10,       32'h0,        32'hDEAD55EF, 1'b0},
            {1'b0, FH,     32'h11,       32'h0,        32'h0,        1'b1},
            {1'b0, FHU,    32'h13,       32'h0,        32'h0,        1'b1},
            {1'b1, FH,     32'h11,       32'h0000FFFF, 32'h0,        1'b1},
            {1'b1, FW,     32'h12,       32'h01234567, 32'h0,        1'b1},
            {1'b1, FBU,    32'h10,       32'h000000AA, 32'h0,        1'b1},
            {1'b1, FHU,    32'h10,       32'h0000AAAA, 32'h0,        1'b1},
            {1'b0, 3'b011, 32'h10,       32'h0,        32'h0,        1'b1},
            {1'b0, 3'b110, 32'h10,       32'h0,        32'h0,        1'b1},
            {1'b1, 3'b111, 32'h10,       32'hFFFFFFFF, 32'h0,        1'b1},
            {1'b0, FW,     32'h400,      32'h0,        32'h0,        1'b1},
            {1'b1, FW,     32'h400,      32'h77777777, 32'h0,        1'b1},
            {1'b1, FW,     32'h10000010, 32'h66666666, 32'h0,        1'b1},
            {1'b0, FW,     32'h10000010, 32'h0,        32'h0,        1'b1},
            {1'b1, FW,     32'h3FC,      32'h12345678, 32'h0,        1'b0},
            {1'b0, FW,     32'h3FC,      32'h0,        32'h12345678, 1'b0},
            {1'b0, FBU,    32'h3FF,      32'h0,        32'h00000012, 1'b0},
            {1'b0, FW,     32'h0,        32'h0,        32'h0,        1'b0},
            {1'b0, FW,     32'h10,       32'h0,        32'hDEAD55EF, 1'b0}
        };
        logic ok, ae;
        logic [31:0] ar;
        exp_t e;
        int lat;
        sel = 1'b0;
        // Word 0 must read back what was stored there, not an aliased 0x400 or 0x10000010.
        sb.push_back({32'h0, 1'b0});
        issue(1'b1, FW, 32'h0, 32'h0, ok);
        if (ok) collect(ar, ae, e, lat);
        else void'(sb.pop_back());
        foreach (tbl[i]) begin
            sb.push_back({tbl[i].rdata, tbl[i].err});
            issue(tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wdata, ok);
            if (!ok) begin
                void'(sb.pop_back());
                continue;
            end
            collect(ar, ae, e, lat);
            checks++;
            if (ar !== e.rdata || ae !== e.err || lat != 1) begin
                fails++;
                $display("FAIL store_err[%0d] got rdata=%h err=%b lat=%0d, required rdata=%h err=%b lat=1",
                         i, ar, ae, lat, e.rdata, e.err);
            end
        end
    endtask

    task automatic test_random_model();
        logic [7:0] mb [32];
        logic [2:0] codes [5] = '{FB, FH, FW, FBU, FHU};
        logic ok, ae, we, err;
        logic [31:0] ar, wd, exp_r;
        logic [2:0] f3;
        exp_t e;
        int lat, a;
        sel = 1'b0;
        for (int n = 0; n < 48; n++) begin
            if (n < 8) begin
                we = 1'b1; f3 = FW; a = 4 * n;
            end else begin
                we = 1'($urandom_range(0, 1)); f3 = codes[$urandom_range(0, 4)];
                a = $urandom_range(0, 31);
            end
            wd  = $urandom;
            err = (we && f3[2]) || (f3[1:0] == 2'b01 && a[0]) || (f3 == FW && a[1:0] != 2'b00);
            exp_r = 32'h0;
            if (!err && we) begin
                mb[a] = wd[7:0];
                if (f3 != FB) mb[a+1] = wd[15:8];
                if (f3 == FW) begin
                    mb[a+2] = wd[23:16];
                    mb[a+3] = wd[31:24];
                end
            end else if (!err) begin
                case (f3)
                    FB:  exp_r = {{24{mb[a][7]}}, mb[a]};
                    FBU: exp_r = {24'h0, mb[a]};
                    FH:  exp_r = {{16{mb[a+1][7]}}, mb[a+1], mb[a]};
                    FHU: exp_r = {16'h0, mb[a+1], mb[a]};
                    default: exp_r = {mb[a+3], mb[a+2], mb[a+1], mb[a]};
                endcase
            end
            sb.push_back({exp_r, err});
            issue(we, f3, 32'h100 + 32'(a), wd, ok);
            if (!ok) begin
                void'(sb.pop_back());
                continue;
            end
            collect(ar, ae, e, lat);
            checks++;
            if (ar !== e.rdata || ae !== e.err || lat != 1) begin
                fails++;
                $display("FAIL random[%0d] we=%b f3=%b a=%0d got rdata=%h err=%b lat=%0d, required rdata=%h err=%b lat=1",
                         n, we, f3, a, ar, ae, lat, e.rdata, e.err);
            end
        end
    endtask

    task automatic test_backpressure();
        logic ok, ae;
        logic [31:0] ar;
        exp_t e;
        int lat;
        sel = 1'b1;
        rsp_ready = 1'b1;
        sb.push_back({32'h0, 1'b0});
        issue(1'b1, FW, 32'h20, 32'hCAFEF00D, ok);
        if (ok) begin
            collect(ar, ae, e, lat);
            checks++;
            if (lat != 4 || ae !== 1'b0) begin
                fails++;
                $display("FAIL bp_store got lat=%0d err=%b, required lat=4 err=0", lat, ae);
            end
        end else void'(sb.pop_back());

        rsp_ready = 1'b0;
        sb.push_back({32'hCAFEF00D, 1'b0});
        issue(1'b0, FW, 32'h20, 32'h0, ok);
        for (int k = 1; k < 4; k++) begin
            checks++;
            if ({rsp_valid, rsp_err, rsp_rdata, req_ready} !== '0) begin
                fails++;
                $display("FAIL bp_wait[%0d] got valid=%b err=%b rdata=%h ready=%b, required all 0",
                         k, rsp_valid, rsp_err, rsp_rdata, req_ready);
            end
            @(posedge clk);
            #1;
        end
        checks++;
        if (rsp_valid !== 1'b1) begin
            fails++;
            $display("FAIL bp_latency got valid=%b 4 cycles after accept, required 1", rsp_valid);
        end
        e = (sb.size() > 0) ? sb.pop_front() : '0;
        // A store presented while busy must be ignored.
        req_we = 1'b1; req_funct3 = FW; req_addr = 32'h20; req_wdata = 32'hBADBAD00;
        req_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (rsp_valid !== 1'b1 || rsp_rdata !== e.rdata || rsp_err !== e.err || req_ready !== 1'b0) begin
                fails++;
                $display("FAIL bp_hold[%0d] got valid=%b rdata=%h err=%b ready=%b, required 1 %h %b 0",
                         k, rsp_valid, rsp_rdata, rsp_err, req_ready, e.rdata, e.err);
            end
            @(posedge clk);
            #1;
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        checks++;
        if (rsp_valid !== 1'b1 || req_ready !== 1'b0) begin
            fails++;
            $display("FAIL bp_pre_handshake got valid=%b ready=%b, required 1 0", rsp_valid, req_ready);
        end
        @(posedge clk);
        #1;
        checks++;
        if (rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0 || req_ready !== 1'b1) begin
            fails++;
            $display("FAIL bp_post_handshake got valid=%b rdata=%h err=%b ready=%b, required 0 0 0 1",
                     rsp_valid, rsp_rdata, rsp_err, req_ready);
        end

        sb.push_back({32'hCAFEF00D, 1'b0});
        issue(1'b0, FW, 32'h20, 32'h0, ok);
        if (ok) begin
            collect(ar, ae, e, lat);
            checks++;
            if (ar !== e.rdata || ae !== e.err || lat != 4) begin
                fails++;
                $display("FAIL bp_ignored_store got rdata=%h err=%b lat=%0d, required rdata=%h err=%b lat=4",
                         ar, ae, lat, e.rdata, e.err);
            end
        end else void'(sb.pop_back());
    endtask

    task automatic test_reset_mid();
        logic ok, ae, seen;
        logic [31:0] ar;
        exp_t e;
        int lat;
        sel = 1'b1;
        rsp_ready = 1'b1;
        issue(1'b1, FW, 32'h24, 32'h11112222, ok);
        reset = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (rv3 !== 1'b0 || rr3 !== 1'b0 || rd3 !== 32'h0) begin
            fails++;
            $display("FAIL mid_reset got valid=%b ready=%b rdata=%h, required 0 0 0", rv3, rr3, rd3);
        end
        reset = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1;
            seen = seen | rv3;
        end
        checks++;
        if (seen !== 1'b0 || rr3 !== 1'b1) begin
            fails++;
            $display("FAIL mid_reset_discard got late_valid=%b ready=%b, required 0 1", seen, rr3);
        end
        sb.push_back({32'h11112222, 1'b0});
        sb.push_back({32'hCAFEF00D, 1'b0});
        for (int k = 0; k < 2; k++) begin
            issue(1'b0, FW, (k == 0) ? 32'h24 : 32'h20, 32'h0, ok);
            if (!ok) begin
                void'(sb.pop_front());
                continue;
            end
            collect(ar, ae, e, lat);
            checks++;
            if (ar !== e.rdata || ae !== e.err || lat != 4) begin
                fails++;
                $display("FAIL post_reset_load[%0d] got rdata=%h err=%b lat=%0d, required rdata=%h err=%b lat=4",
                         k, ar, ae, lat, e.rdata, e.err);
            end
        end
        sel = 1'b0;
        sb.push_back({32'hDEAD55EF, 1'b0});
        issue(1'b0, FW, 32'h10, 32'h0, ok);
        if (ok) begin
            collect(ar, ae, e, lat);
            checks++;
            if (ar !== e.rdata || ae !== e.err || lat != 1) begin
                fails++;
                $display("FAIL post_reset_keep got rdata=%h err=%b lat=%0d, required rdata=%h err=%b lat=1",
                         ar, ae, lat, e.rdata, e.err);
            end
        end else void'(sb.pop_back());
    endtask

    initial begin
        test_reset();
        test_word_and_extend();
        test_byte_store_and_errors();
        test_random_model();
        test_backpressure();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/data_memory_responder.md
DATA_MEMORY_RESPONDER -- requirements
Module: data_memory_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 256: number of 32-bit words of storage; byte address range 0 .. 4*DEPTH_WORDS-1.
REQ-002 Parameter WAIT_CYCLES, default 0: extra cycles inserted between request acceptance and response; range 0..15.
REQ-003 clk  input  1  clock, all state updates on the rising edge.
REQ-004 reset  input  1  synchronous, active-low reset.
REQ-005 req_valid  input  1  core presents a load/store request.
REQ-006 req_ready  output  1  responder can accept a request this cycle.
REQ-007 req_we  input  1  1 = store, 0 = load.
REQ-008 req_addr  input  32  byte address.
REQ-009 req_funct3  input  3  RV32I width code: 000 B, 001 H, 010 W, 100 BU, 101 HU; BU/HU are loads only.
REQ-010 req_wdata  input  32  store data, LSB-aligned.
REQ-011 rsp_valid  output  1  response available.
REQ-012 rsp_ready  input  1  core accepts the response.
REQ-013 rsp_rdata  output  32  load result, sign- or zero-extended; 0 for stores and errors.
REQ-014 rsp_err  output  1  request was misaligned, out of range, or had an illegal funct3.

Function
REQ-015 The block SHALL be an FSM with states IDLE, WAIT, RESP, and SHALL hold at most one transaction outstanding.
REQ-016 req_ready SHALL be 1 only in IDLE; a request SHALL be accepted at the rising edge where req_valid=1 and req_ready=1.
REQ-017 On the accepting edge, a legal store SHALL write the addressed bytes: SB one byte at addr[1:0], SH the half at addr[1], SW the whole word.
REQ-018 On the accepting edge, a legal load SHALL capture the extended result: LB/LH sign-extend, LBU/LHU zero-extend, LW unchanged.
REQ-019 Error conditions SHALL be:
  - H/HU with addr[0]=1;
  - W with addr[1:0]!=00;
  - addr >= 4*DEPTH_WORDS;
  - funct3 of 011, 110 or 111;
  - a store with BU or HU.
REQ-020 An erroring request SHALL NOT modify storage, and SHALL respond with rsp_err=1 and rsp_rdata=0.
REQ-021 After acceptance: if WAIT_CYCLES=0 the next state SHALL be RESP; otherwise WAIT.
REQ-022 In WAIT, a down-counter loaded with WAIT_CYCLES-1 SHALL be decremented each cycle, and the FSM SHALL go to RESP when the counter reads 0.
REQ-023 In RESP, rsp_valid SHALL be 1, and rsp_rdata/rsp_err SHALL be held stable until rsp_ready=1.
REQ-024 On the response handshake edge the FSM SHALL return to IDLE.
REQ-025 Response latency SHALL be exactly 1+WAIT_CYCLES cycles from the accepting edge to the first cycle with rsp_valid=1; back-pressure on rsp_ready only extends RESP.
REQ-026 rsp_valid SHALL be 0 in IDLE and WAIT. rsp_rdata and rsp_err SHALL be 0 whenever rsp_valid=0.
REQ-027 A request presented while not ready SHALL be ignored, with no side effect; the requester holds it.
REQ-028 A store followed immediately by a load to the same word SHALL return the newly written data.
REQ-029 Address bits above the word index range SHALL be checked for the range error and SHALL NOT wrap.

Reset
REQ-030 While reset=0 at a rising edge, the block SHALL enter IDLE, clear the wait counter, and drive rsp_valid=0, rsp_rdata=0, rsp_err=0.
REQ-031 req_ready SHALL be 0 during the reset cycle and 1 on the first cycle after reset deasserts.
REQ-032 Reset mid-transaction SHALL discard the pending response. Any store already committed on its accepting edge SHALL remain.
REQ-033 Storage contents SHALL NOT be cleared by reset.

Structure
REQ-034 The funct3 width codes and the FSM state encoding SHALL reside in the shared package core_pkg.
REQ-035 Byte-lane selection and sign/zero extension SHALL be a combinational sub-module load_align_extend (inputs word, addr[1:0], funct3; output 32-bit result).

Verification
REQ-036 SW 0xDEADBEEF to 0x10, then LW 0x10 -> rsp_rdata=0xDEADBEEF, rsp_err=0.
REQ-037 After REQ-036, each load from 0x13 -> LB gives 0xFFFFFFDE, LBU gives 0x000000DE, and LH 0x12 gives 0xFFFFDEAD.
REQ-038 SB 0x55 to 0x11, then LW 0x10 -> 0xDEAD55EF. Also: LH 0x11 -> rsp_err=1, rsp_rdata=0, and the word is unchanged.
REQ-039 WAIT_CYCLES=3 with rsp_ready held 0 for 5 cycles:
  - rsp_valid rises exactly 4 cycles after acceptance;
  - data stays stable while rsp_ready=0;
  - req_ready=0 until the cycle after the handshake.
REQ-040 Reset=0 asserted in WAIT -> next cycle state is IDLE with rsp_valid=0 and no response is issued; also LW 0x400 with DEPTH_WORDS=256 -> rsp_err=1.
